// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: instruction field layout, FSM encoding
// and the field decoder used by instruction_fetch.
package fetch_pkg;

  localparam int unsigned INSTR_WIDTH = 9;
  localparam int unsigned FORMAT_BIT  = 8;
  localparam int unsigned OPCODE_MSB  = 7;
  localparam int unsigned OPCODE_LSB  = 4;
  localparam int unsigned SIGN_BIT    = 3;
  localparam int unsigned OPERAND_MSB = 2;
  localparam int unsigned OPERAND_LSB = 0;
  localparam int unsigned IMM_MSB     = 7;
  localparam int unsigned IMM_LSB     = 0;

  localparam logic [3:0] HALT_OPCODE_DEFAULT = 4'b1111;

  typedef enum logic {
    StRun    = 1'b0,
    StHalted = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic       format;
    logic [3:0] opcode;
    logic       sign;
    logic [2:0] operand;
    logic [7:0] immediate;
  } instr_fields_t;

  // Fields that do not belong to the instruction's format are forced to zero.
  function automatic instr_fields_t decode_instr(input logic [INSTR_WIDTH-1:0] instr);
    instr_fields_t f;
    f        = '0;
    f.format = instr[FORMAT_BIT];
    if (!f.format) begin
      f.opcode  = instr[OPCODE_MSB:OPCODE_LSB];
      f.sign    = instr[SIGN_BIT];
      f.operand = instr[OPERAND_MSB:OPERAND_LSB];
    end else begin
      f.immediate = instr[IMM_MSB:IMM_LSB];
    end
    return f;
  endfunction

endpackage

// File: rtl/program_counter.sv
// Fetch program counter: load has priority over hold; otherwise increments,
// wrapping naturally at 2^PC_WIDTH.
module program_counter #(
  parameter int unsigned          PC_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                load_i,
  input  logic [PC_WIDTH-1:0] target_i,
  input  logic                hold_i,
  output logic [PC_WIDTH-1:0] pc_o
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i;
    end else if (!hold_i) begin
      pc_d = pc_q + PC_WIDTH'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives the instruction memory from the PC, registers the decoded
// fields with a valid bit, and raises a one-cycle flush on branch redirect.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH    = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [3:0]          HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic                   out_format,
  output logic [3:0]             out_opcode,
  output logic                   out_sign,
  output logic [2:0]             out_operand,
  output logic [7:0]             out_immediate,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic                   out_valid,
  output logic                   flush,
  output logic                   halted
);

  fetch_state_e        state_q, state_d;
  instr_fields_t       fields_q, fields_d;
  logic [PC_WIDTH-1:0] out_pc_q, out_pc_d;
  logic                out_valid_q, out_valid_d;
  logic                flush_q, flush_d;

  logic [PC_WIDTH-1:0] pc;
  logic                pc_load;
  logic                pc_hold;
  instr_fields_t       fetched;
  logic                is_halt;

  assign fetched = decode_instr(imem_data);
  assign is_halt = !fetched.format && (fetched.opcode == HALT_OPCODE);

  program_counter #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_program_counter (
    .clock_i  (clock),
    .reset_i  (reset),
    .load_i   (pc_load),
    .target_i (redirect_target),
    .hold_i   (pc_hold),
    .pc_o     (pc)
  );

  always_comb begin
    state_d     = state_q;
    fields_d    = fields_q;
    out_pc_d    = out_pc_q;
    out_valid_d = out_valid_q;
    flush_d     = 1'b0;
    pc_load     = 1'b0;
    pc_hold     = 1'b1;
    unique case (state_q)
      StRun: begin
        // Redirect outranks both stall and halt decode.
        if (redirect_valid) begin
          pc_load     = 1'b1;
          fields_d    = '0;
          out_pc_d    = '0;
          out_valid_d = 1'b0;
          flush_d     = 1'b1;
        end else if (!stall) begin
          fields_d    = fetched;
          out_pc_d    = pc;
          out_valid_d = 1'b1;
          if (is_halt) begin
            state_d = StHalted;
          end else begin
            pc_hold = 1'b0;
          end
        end
      end
      StHalted: begin
        out_valid_d = 1'b0;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      fields_q    <= '0;
      out_pc_q    <= '0;
      out_valid_q <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fields_q    <= fields_d;
      out_pc_q    <= out_pc_d;
      out_valid_q <= out_valid_d;
      flush_q     <= flush_d;
    end
  end

  assign imem_addr     = pc;
  assign out_format    = fields_q.format;
  assign out_opcode    = fields_q.opcode;
  assign out_sign      = fields_q.sign;
  assign out_operand   = fields_q.operand;
  assign out_immediate = fields_q.immediate;
  assign out_pc        = out_pc_q;
  assign out_valid     = out_valid_q;
  assign flush         = flush_q;
  assign halted        = (state_q == StHalted);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: expected fetches are queued when driven
// and compared when the registered fields appear one cycle later.
module tb_instruction_fetch;

  logic       clock;
  logic       reset;
  logic       stall;
  logic       redirect_valid;
  logic [9:0] redirect_target;
  logic [9:0] imem_addr;
  logic [8:0] imem_data;
  logic       out_format;
  logic [3:0] out_opcode;
  logic       out_sign;
  logic [2:0] out_operand;
  logic [7:0] out_immediate;
  logic [9:0] out_pc;
  logic       out_valid;
  logic       flush;
  logic       halted;

  logic [8:0] mem [1024];
  assign imem_data = mem[imem_addr];

  instruction_fetch u_dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .out_format      (out_format),
    .out_opcode      (out_opcode),
    .out_sign        (out_sign),
    .out_operand     (out_operand),
    .out_immediate   (out_immediate),
    .out_pc          (out_pc),
    .out_valid       (out_valid),
    .flush           (flush),
    .halted          (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [9:0] pc;
    logic [8:0] word;
  } exp_t;

  exp_t       exp_q[$];
  int         checks;
  int         failures;
  logic [9:0] exp_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_valid"},  32'(out_valid), 32'd1);
    check({tag, "_flush"},  32'(flush), 32'd0);
    check({tag, "_pc"},     32'(out_pc), 32'(e.pc));
    check({tag, "_format"}, 32'(out_format), 32'(e.word[8]));
    check({tag, "_opcode"}, 32'(out_opcode), e.word[8] ? 32'd0 : 32'(e.word[7:4]));
    check({tag, "_sign"},   32'(out_sign), e.word[8] ? 32'd0 : 32'(e.word[3]));
    check({tag, "_oper"},   32'(out_operand), e.word[8] ? 32'd0 : 32'(e.word[2:0]));
    check({tag, "_imm"},    32'(out_immediate), e.word[8] ? 32'(e.word[7:0]) : 32'd0);
  endtask

  task automatic run_cycle(input string tag);
    exp_t e;
    e.pc   = exp_pc;
    e.word = mem[exp_pc];
    exp_q.push_back(e);
    tick();
    compare_out(tag);
    exp_pc = exp_pc + 10'd1;
  endtask

  initial begin
    logic [8:0] w;
    checks          = 0;
    failures        = 0;
    reset           = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    // Fill memory with non-halt words.
    for (int i = 0; i < 1024; i++) begin
      w = 9'(i * 37 + 5);
      if (!w[8] && w[7:4] == 4'hF) w[8] = 1'b1;
      mem[i] = w;
    end
    mem[0] = 9'h012;
    mem[1] = 9'h1A5;
    mem[3] = 9'h034;

    // Reset state.
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_out_pc", 32'(out_pc), 32'd0);
    check("rst_fields", {out_format, out_opcode, out_sign, out_operand, out_immediate}, 32'd0);
    reset  = 1'b0;
    exp_pc = 10'd0;

    // Sequential fetch from 0, then explicit spot checks of the first two words.
    run_cycle("f0");
    run_cycle("f1");
    check("f1_imm_a5", 32'(out_immediate), 32'hA5);
    run_cycle("f2");
    run_cycle("f3");
    run_cycle("f4");
    check("pc5_addr", 32'(imem_addr), 32'd5);

    // Stall three cycles at pc=5.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", 32'(imem_addr), 32'd5);
      check("stall_out_pc", 32'(out_pc), 32'd4);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_flush", 32'(flush), 32'd0);
      check("stall_opcode", 32'(out_opcode), 32'(mem[4][8] ? 4'd0 : mem[4][7:4]));
    end
    stall = 1'b0;
    run_cycle("resume5");
    run_cycle("resume6");

    // Redirect while stalled.
    stall           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 10'h040;
    tick();
    check("redir_flush", 32'(flush), 32'd1);
    check("redir_valid", 32'(out_valid), 32'd0);
    check("redir_addr", 32'(imem_addr), 32'h040);
    check("redir_fields", {out_format, out_opcode, out_sign, out_operand, out_immediate}, 32'd0);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    exp_pc         = 10'h040;
    run_cycle("after_redir");

    // Back-to-back redirects; last target wins.
    redirect_valid  = 1'b1;
    redirect_target = 10'h100;
    tick();
    check("b2b_flush1", 32'(flush), 32'd1);
    redirect_target = 10'h200;
    tick();
    check("b2b_flush2", 32'(flush), 32'd1);
    check("b2b_addr", 32'(imem_addr), 32'h200);
    redirect_valid = 1'b0;
    exp_pc         = 10'h200;
    run_cycle("b2b_fetch");

    // PC wrap.
    redirect_valid  = 1'b1;
    redirect_target = 10'h3FE;
    tick();
    redirect_valid = 1'b0;
    exp_pc         = 10'h3FE;
    run_cycle("wrap_3fe");
    run_cycle("wrap_3ff");
    check("wrap_addr", 32'(imem_addr), 32'd0);

    // Asynchronous reset arriving together with a redirect, while flush is high.
    redirect_valid  = 1'b1;
    redirect_target = 10'h155;
    tick();
    check("pre_rst_flush", 32'(flush), 32'd1);
    redirect_target = 10'h2AA;
    #2;
    reset = 1'b1;
    #1;
    check("arst_addr", 32'(imem_addr), 32'd0);
    check("arst_flush", 32'(flush), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    tick();
    check("arst_hold_addr", 32'(imem_addr), 32'd0);
    redirect_valid = 1'b0;
    reset          = 1'b0;
    exp_q.delete();

    // Halt word at address 3.
    mem[3] = 9'h0F0;
    exp_pc = 10'd0;
    run_cycle("h0");
    run_cycle("h1");
    run_cycle("h2");
    run_cycle("halt_word");
    check("halt_word_opcode", 32'(out_opcode), 32'hF);
    check("halt_addr_hold", 32'(imem_addr), 32'd3);
    tick();
    check("halted_flag", 32'(halted), 32'd1);
    check("halted_valid", 32'(out_valid), 32'd0);
    check("halted_addr", 32'(imem_addr), 32'd3);
    redirect_valid  = 1'b1;
    redirect_target = 10'h040;
    stall           = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("halted_redir_addr", 32'(imem_addr), 32'd3);
      check("halted_redir_flush", 32'(flush), 32'd0);
      check("halted_redir_flag", 32'(halted), 32'd1);
      check("halted_redir_valid", 32'(out_valid), 32'd0);
    end
    redirect_valid = 1'b0;
    stall          = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage of the 141L pipeline. Holds the program counter, drives the instruction-memory address, and splits each 9-bit instruction into format/opcode/sign/operand/immediate fields. It registers those fields with a valid bit and produces the flush pulse for register_id, the downstream IF/ID register. Handles stall, branch redirect and the halt instruction.

Parameters:
PC_WIDTH, 10, program counter / instruction memory address width
RESET_PC, 0, PC value loaded on reset
HALT_OPCODE, 4'b1111, format-0 opcode that stops fetch

Ports:
clock  input  1  pipeline clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
stall  input  1  hold PC and output fields this cycle
redirect_valid  input  1  branch taken; load redirect_target
redirect_target  input  PC_WIDTH  new PC on redirect
imem_addr  output  PC_WIDTH  instruction memory address, combinationally equal to pc
imem_data  input  9  instruction word, combinational read of imem_addr
out_format  output  1  instruction bit [8]
out_opcode  output  4  bits [7:4] (format 0), else 0
out_sign  output  1  bit [3] (format 0), else 0
out_operand  output  3  bits [2:0] (format 0), else 0
out_immediate  output  8  bits [7:0] (format 1), else 0
out_pc  output  PC_WIDTH  PC of the instruction currently on the out_* fields
out_valid  output  1  out_* fields hold a real instruction
flush  output  1  one-cycle pulse to register_id to squash in-flight instruction
halted  output  1  fetch stopped by halt instruction

Behaviour:
- Reset (async, any time, including mid-redirect): pc=RESET_PC, state=RUN, all out_* fields=0, out_pc=0, out_valid=0, flush=0, halted=0.
- States: RUN and HALTED.
- RUN, no stall, no redirect, at posedge:
  - fields decoded from imem_data are registered onto out_*;
  - out_pc<=pc, out_valid<=1, pc<=pc+1.
  - Latency is 1 cycle from address to fields.
- PC wrap: pc at 2^PC_WIDTH-1 increments to 0. This is not an error.
- Field decode: for format 0, out_immediate=0. For format 1, out_opcode, out_sign and out_operand are 0. Unused fields are forced to zero.
- Stall (RUN, no redirect): pc and all out_* held; flush=0.
- Redirect (RUN; has priority over stall and halt decode):
  - pc<=redirect_target, out_valid<=0, out_* fields<=0, flush<=1 for exactly one cycle.
  - Next cycle fetches from redirect_target.
  - Back-to-back redirects each produce a flush pulse; the last target wins.
- Halt: in RUN with no stall and no redirect, a fetched word with format 0 and opcode HALT_OPCODE is registered normally (out_valid=1).
  - pc does not increment; state<=HALTED.
- HALTED:
  - halted=1, out_valid<=0, pc frozen.
  - stall and redirect are ignored; flush stays 0.
  - Exit only via reset.
- flush is registered. It is never high while out_valid=1.

Decomposition:
- Shared package fetch_pkg holds:
  - instruction field bit positions (FORMAT_BIT=8, OPCODE_MSB/LSB=7/4, SIGN_BIT=3, OPERAND_MSB/LSB=2/0);
  - HALT_OPCODE default;
  - the state encoding (RUN=0, HALTED=1).
- One sub-module: program_counter, covering PC register, increment/wrap, load on redirect, and hold on stall/halt.
- Field decode and output registers stay in instruction_fetch.

Test Plan:
- Reset released, imem holds 9'h012, 9'h1A5 at addr 0,1 -> cycle1: out_format=0, opcode=1, sign=0, operand=2, out_pc=0, valid=1. Cycle2: format=1, immediate=8'hA5, opcode=0, out_pc=1.
- stall held 3 cycles at pc=5 -> imem_addr stays 5, out_* unchanged, flush=0. Release resumes at 5 then 6.
- redirect_valid with target=10'h040 while stall=1 -> flush=1 for one cycle, out_valid=0, next fetch addr 0x040, then out_pc=0x040.
- pc=10'h3FF, no stall -> next imem_addr=0.
- Halt word 9'h0F0 at addr 3 -> out_valid=1 with opcode F, then halted=1, out_valid=0, imem_addr stuck at 3. A later redirect is ignored.
- reset asserted same cycle as redirect_valid -> pc=RESET_PC, flush=0, out_valid=0 immediately (asynchronous).
